sd_tx_cmd: RTL and testbench
============================

# sd_tx_cmd

Parallel-to-serial SD SPI transmitter: the MOSI counterpart of the MISO shift receiver in the SD card interface. It serializes either a full 48-bit SD command frame or a single raw byte onto MOSI, MSB first, advancing one bit per SCLK falling-edge strobe. Command frames get their CRC7 computed on the fly. It is driven by the SD controller FSM, which supplies command index, argument and start pulses, and consumes the done pulses.

## Interface
- No parameters. The frame format is fixed by SD SPI mode: 48-bit command, CRC7 polynomial x^7+x^3+1.
- clk  input  1  system clock
- n_rst  input  1  asynchronous, active-low reset
- falling_edge_sclk  input  1  one-clk-wide strobe marking an SCLK falling edge
- start_cmd  input  1  one-cycle request to send a command frame
- cmd_index  input  6  SD command number, sampled on accepted start_cmd
- cmd_arg  input  32  command argument, sampled on accepted start_cmd
- start_byte  input  1  one-cycle request to send one raw byte
- tx_byte  input  8  byte to send, sampled on accepted start_byte
- MOSI  output  1  serial data to card; idle level 1
- busy  output  1  high while a frame or byte is in progress
- cmd_done  output  1  one-cycle pulse when a command frame completes
- byte_done  output  1  one-cycle pulse when a raw byte completes

## Operation
- Reset values: MOSI=1, busy=0, cmd_done=0, byte_done=0, state IDLE, bit counter 0, CRC 0.
- States:
  - IDLE
  - CMD_HDR: frame bits 47..8 (start 0, transmission 1, index[5:0], arg[31:0])
  - CMD_CRC: frame bits 7..1
  - CMD_END: frame bit 0 = 1
  - BYTE: 8 bits
- IDLE + start_cmd:
  - Latch {2'b01, cmd_index, cmd_arg} into a 40-bit shift register.
  - Clear CRC, set bit counter to 0, go to CMD_HDR, set busy=1.
  - MOSI=0 (start bit) from the next clk.
- IDLE + start_byte (start_cmd low): latch tx_byte, go to BYTE, busy=1, MOSI=tx_byte[7] from the next clk.
- start_cmd and start_byte together: start_cmd wins; start_byte is dropped.
- Any start while busy is ignored. No queuing, no error flag.
- CMD_HDR, on each falling_edge_sclk:
  - Feed the current MOSI bit into the CRC7, shift, increment the counter.
  - After 40 bits go to CMD_CRC; MOSI=crc[6] of the CRC over all 40 header bits.
- CMD_CRC: shift CRC bits MSB first, one per strobe. After 7 bits go to CMD_END with MOSI=1.
- CMD_END, next strobe:
  - Go to IDLE, MOSI=1, busy=0.
  - cmd_done=1 for exactly that one cycle.
- BYTE: shift one bit per strobe. The strobe after bit 0 returns to IDLE with MOSI=1, busy=0 and byte_done pulsed.
- A strobe in the same cycle as an accepted start is ignored; shifting begins at the next strobe.
- Strobes in IDLE have no effect; MOSI stays 1.
- CRC7 update per bit b: fb = crc[6]^b; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0).

## Timing
- Start to first bit on MOSI: 1 clk.
- Bit hold: each bit is valid from one falling_edge_sclk to the next, so the card samples it on the intervening rising edge.
- Command frame: exactly 48 strobes after acceptance; busy falls and cmd_done pulses on the clk after the 48th strobe.
- Raw byte: exactly 8 strobes; same completion timing via byte_done.
- Back-to-back: a start may be accepted in the cycle right after busy falls.
- MOSI, busy and the done pulses are all registered outputs.
- Async reset mid-frame: MOSI=1 and busy=0 immediately, with no done pulse. The partial frame is lost, and the controller must resend.

## Structure
- Shared package sd_pkg holds:
  - the state enum (IDLE, CMD_HDR, CMD_CRC, CMD_END, BYTE)
  - CMD_FRAME_BITS=48, CMD_HDR_BITS=40, CRC7_POLY=7'h09, MOSI_IDLE=1'b1
- Sub-module sd_crc7: serial CRC7 register with clk, n_rst, clear, enable, bit_in, crc[6:0]. It is reused later by a response checker.
- Top level holds the FSM, a 6-bit bit counter, the 40-bit header shift register, the 8-bit byte shift register and the output registers.

## Test plan
- CMD0, arg 0x00000000, 48 strobes -> MOSI bytes 0x40 00 00 00 00 95; cmd_done pulses once; busy high for the whole frame.
- CMD8, arg 0x000001AA -> bytes 0x48 00 00 01 AA 87.
- start_byte with tx_byte=0xFE -> MOSI 1,1,1,1,1,1,1,0 over 8 strobes; byte_done pulses; MOSI returns to 1.
- start_cmd and start_byte in the same cycle, then start_byte again mid-frame -> only the command frame is sent; byte_done never pulses.
- Start coincident with a strobe, and idle strobes -> no bit lost; the frame still takes exactly 48 strobes; MOSI stays 1 while idle.
- n_rst asserted after 20 strobes of CMD17 -> MOSI=1 and busy=0 asynchronously; no done pulse; a following CMD0 is sent correctly (… 95).

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI interface blocks.
// Holds the transmitter state encoding, the SD command frame geometry,
// the CRC7 polynomial, the MOSI idle level, and a one-bit CRC7 step
// function. The CRC7 register and the command transmitter both use it.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD_HDR,
        CMD_CRC,
        CMD_END,
        BYTE
    } tx_state_e;

    localparam int         CMD_FRAME_BITS = 48;
    localparam int         CMD_HDR_BITS   = 40;
    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam logic       MOSI_IDLE      = 1'b1;

    // One serial CRC7 update (x^7 + x^3 + 1), data bit fed MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 register for SD command/response frames.
// Ports:
//   clk, n_rst  - clock, asynchronous active-low reset (clears CRC)
//   clear       - synchronous clear, has priority over enable
//   enable      - absorb bit_in into the CRC this clock
//   bit_in      - serial data bit, MSB of the frame first
//   crc[6:0]    - running CRC7 remainder
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_tx_cmd.sv
// SD SPI MOSI transmitter. Serializes a 48-bit command frame
// (start 0, transmission 1, index, argument, CRC7, end 1) or a single raw
// byte, MSB first, one bit per SCLK falling-edge strobe.
// Ports:
//   clk, n_rst         - clock, asynchronous active-low reset
//   falling_edge_sclk  - one-clk strobe, advances one bit
//   start_cmd          - request a command frame (wins over start_byte)
//   cmd_index[5:0]     - command number, sampled on accepted start_cmd
//   cmd_arg[31:0]      - command argument, sampled on accepted start_cmd
//   start_byte         - request a raw byte
//   tx_byte[7:0]       - byte to send, sampled on accepted start_byte
//   MOSI               - registered serial data, idles at 1
//   busy               - registered, high while a transfer is in progress
//   cmd_done           - registered one-clk pulse at end of a command frame
//   byte_done          - registered one-clk pulse at end of a raw byte
module sd_tx_cmd
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        falling_edge_sclk,
    input  logic        start_cmd,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        start_byte,
    input  logic [7:0]  tx_byte,
    output logic        MOSI,
    output logic        busy,
    output logic        cmd_done,
    output logic        byte_done
);

    localparam int CRC_BITS = CMD_FRAME_BITS - CMD_HDR_BITS - 1;

    tx_state_e   state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic [39:0] hdr_sr, hdr_d;
    logic [7:0]  byte_sr, byte_d;
    logic        mosi_d, busy_d, cmd_done_d, byte_done_d;
    logic        crc_clr, crc_en;
    logic [6:0]  crc, crc_final;

    sd_crc7 u_crc7 (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (crc_clr),
        .enable (crc_en),
        .bit_in (MOSI),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            MOSI      <= MOSI_IDLE;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            MOSI      <= mosi_d;
            busy      <= busy_d;
            cmd_done  <= cmd_done_d;
            byte_done <= byte_done_d;
        end
    end

    // Shift registers carry data only; their contents are don't-care
    // until a start loads them.
    always_ff @(posedge clk) begin
        hdr_sr  <= hdr_d;
        byte_sr <= byte_d;
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hdr_d       = hdr_sr;
        byte_d      = byte_sr;
        mosi_d      = MOSI;
        busy_d      = busy;
        cmd_done_d  = 1'b0;
        byte_done_d = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        // CRC including the bit currently on MOSI, i.e. the final header CRC
        // when the last header bit is being shifted out.
        crc_final   = crc7_step(crc, MOSI);

        case (state)
            IDLE: begin
                mosi_d = MOSI_IDLE;
                busy_d = 1'b0;
                if (start_cmd) begin
                    hdr_d   = {2'b01, cmd_index, cmd_arg};
                    crc_clr = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = CMD_HDR;
                    busy_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else if (start_byte) begin
                    byte_d  = tx_byte;
                    cnt_d   = 6'd0;
                    state_d = BYTE;
                    busy_d  = 1'b1;
                    mosi_d  = tx_byte[7];
                end
            end

            // hdr_sr[39] is already on MOSI, so the next bit comes from [38].
            CMD_HDR: begin
                if (falling_edge_sclk) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt + 6'd1;
                    if (cnt == 6'(CMD_HDR_BITS - 1)) begin
                        // Reuse the header register to shift the CRC out:
                        // crc[6] goes straight to MOSI, crc[5:0] wait at the top.
                        state_d = CMD_CRC;
                        cnt_d   = 6'd0;
                        mosi_d  = crc_final[6];
                        hdr_d   = {crc_final[5:0], 34'd0};
                    end else begin
                        mosi_d = hdr_sr[38];
                        hdr_d  = {hdr_sr[38:0], 1'b0};
                    end
                end
            end

            CMD_CRC: begin
                if (falling_edge_sclk) begin
                    cnt_d = cnt + 6'd1;
                    if (cnt == 6'(CRC_BITS - 1)) begin
                        state_d = CMD_END;
                        cnt_d   = 6'd0;
                        mosi_d  = 1'b1;
                    end else begin
                        mosi_d = hdr_sr[39];
                        hdr_d  = {hdr_sr[38:0], 1'b0};
                    end
                end
            end

            CMD_END: begin
                if (falling_edge_sclk) begin
                    state_d    = IDLE;
                    mosi_d     = MOSI_IDLE;
                    busy_d     = 1'b0;
                    cmd_done_d = 1'b1;
                end
            end

            BYTE: begin
                if (falling_edge_sclk) begin
                    cnt_d = cnt + 6'd1;
                    if (cnt == 6'd7) begin
                        state_d     = IDLE;
                        cnt_d       = 6'd0;
                        mosi_d      = MOSI_IDLE;
                        busy_d      = 1'b0;
                        byte_done_d = 1'b1;
                    end else begin
                        // Rotate rather than shift; the wrapped bit is never sent.
                        mosi_d = byte_sr[6];
                        byte_d = {byte_sr[6:0], byte_sr[7]};
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
                mosi_d  = MOSI_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_tx_cmd.sv
module tb_sd_tx_cmd;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        falling_edge_sclk;
    logic        start_cmd;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        start_byte;
    logic [7:0]  tx_byte;
    logic        MOSI;
    logic        busy;
    logic        cmd_done;
    logic        byte_done;

    int checks = 0;
    int errors = 0;

    logic        bitq[$];
    int          doneq[$];
    logic [47:0] cap = 48'd0;

    sd_tx_cmd dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .falling_edge_sclk (falling_edge_sclk),
        .start_cmd         (start_cmd),
        .cmd_index         (cmd_index),
        .cmd_arg           (cmd_arg),
        .start_byte        (start_byte),
        .tx_byte           (tx_byte),
        .MOSI              (MOSI),
        .busy              (busy),
        .cmd_done          (cmd_done),
        .byte_done         (byte_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header followed by the remainder of header*x^7 divided
    // by x^7+x^3+1 (long division), then the end bit.
    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] hdr;
        logic [46:0] rem;
        hdr = {2'b01, idx, arg};
        rem = {hdr, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
        return {hdr, rem[6:0], 1'b1};
    endfunction

    // Monitor: compares every bit presented at a strobe, done pulses and idle level.
    always @(negedge clk) begin
        if (n_rst) begin
            if (falling_edge_sclk && busy) begin
                cap = {cap[46:0], MOSI};
                if (bitq.size() == 0) begin
                    chk("unexpected_bit", 1'b1, 1'b0);
                end else begin
                    logic e;
                    e = bitq.pop_front();
                    chk("mosi_bit", MOSI, e);
                end
            end
            if (!busy) chk("mosi_idle", MOSI, 1'b1);
            if (cmd_done || byte_done) begin
                int kind;
                kind = cmd_done ? (byte_done ? 3 : 1) : 2;
                if (doneq.size() == 0) begin
                    chk("unexpected_done", kind, 0);
                end else begin
                    int e;
                    e = doneq.pop_front();
                    chk("done_kind", kind, e);
                end
                chk("bits_left_at_done", bitq.size(), 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        falling_edge_sclk = 1'b0;
        start_cmd         = 1'b0;
        start_byte        = 1'b0;
    endtask

    task automatic run_strobes(input int n, input int mid_byte_at, input int done_kind);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc();
            if (done_kind != 0 && k == n - 1) chk("busy_before_last", busy, 1'b1);
            falling_edge_sclk = 1'b1;
            if (k == mid_byte_at) begin
                start_byte = 1'b1;
                tx_byte    = 8'($urandom);
            end
            cyc();
        end
        if (done_kind != 0) begin
            chk("busy_after_last", busy, 1'b0);
            if (done_kind == 1) chk("cmd_done_pulse", cmd_done, 1'b1);
            else                chk("byte_done_pulse", byte_done, 1'b1);
            cyc();
            chk("done_one_cycle", {cmd_done, byte_done}, 2'b00);
            chk("queues_drained", bitq.size() + doneq.size(), 0);
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic coinc, input logic with_byte, input int mid_byte);
        logic [47:0] f;
        f          = ref_frame(idx, arg);
        start_cmd  = 1'b1;
        cmd_index  = idx;
        cmd_arg    = arg;
        start_byte = with_byte;
        tx_byte    = 8'($urandom);
        falling_edge_sclk = coinc;
        cyc();
        for (int i = 47; i >= 0; i--) bitq.push_back(f[i]);
        doneq.push_back(1);
        chk("busy_after_start", busy, 1'b1);
        chk("start_bit", MOSI, 1'b0);
        run_strobes(48, mid_byte, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic coinc);
        start_byte = 1'b1;
        tx_byte    = b;
        falling_edge_sclk = coinc;
        cyc();
        for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
        doneq.push_back(2);
        chk("busy_after_byte_start", busy, 1'b1);
        chk("byte_first_bit", MOSI, b[7]);
        run_strobes(8, -1, 2);
    endtask

    initial begin
        n_rst = 1'b0;
        falling_edge_sclk = 1'b0;
        start_cmd = 1'b0;
        start_byte = 1'b0;
        cmd_index = 6'd0;
        cmd_arg = 32'd0;
        tx_byte = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mosi", MOSI, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_dones", {cmd_done, byte_done}, 2'b00);
        n_rst = 1'b1;
        cyc();

        // Strobes while idle do nothing.
        for (int i = 0; i < 5; i++) begin
            falling_edge_sclk = 1'b1;
            cyc();
        end
        chk("idle_strobes_busy", busy, 1'b0);

        send_cmd(6'd0, 32'h0000_0000, 1'b0, 1'b0, -1);
        chk("cmd0_frame", cap, 48'h40_0000_0000_95);

        send_cmd(6'd8, 32'h0000_01AA, 1'b0, 1'b0, -1);
        chk("cmd8_frame", cap, 48'h48_0000_01AA_87);

        send_byte(8'hFE, 1'b0);
        chk("byte_fe", cap[7:0], 8'hFE);

        // Simultaneous starts plus a start_byte mid-frame: only the command goes out.
        send_cmd(6'($urandom), $urandom, 1'b0, 1'b1, 20);

        // Start coincident with a strobe.
        send_cmd(6'd1, $urandom, 1'b1, 1'b0, -1);
        send_byte(8'h5A, 1'b1);

        // Asynchronous reset part-way through CMD17.
        begin
            logic [47:0] f;
            f = ref_frame(6'd17, 32'h0000_0200);
            start_cmd = 1'b1;
            cmd_index = 6'd17;
            cmd_arg   = 32'h0000_0200;
            cyc();
            for (int i = 47; i >= 0; i--) bitq.push_back(f[i]);
            doneq.push_back(1);
            run_strobes(20, -1, 0);
            #2;
            n_rst = 1'b0;
            #1;
            chk("async_rst_mosi", MOSI, 1'b1);
            chk("async_rst_busy", busy, 1'b0);
            bitq.delete();
            doneq.delete();
            cyc();
            cyc();
            n_rst = 1'b1;
            cyc();
            chk("post_rst_busy", busy, 1'b0);
            send_cmd(6'd0, 32'h0000_0000, 1'b0, 1'b0, -1);
            chk("post_rst_cmd0", cap, 48'h40_0000_0000_95);
        end

        // Randomized mix of commands and bytes.
        for (int r = 0; r < 14; r++) begin
            if ($urandom_range(0, 1) == 0)
                send_cmd(6'($urandom), $urandom, 1'($urandom), 1'($urandom),
                         int'($urandom_range(0, 60)) - 10);
            else
                send_byte(8'($urandom), 1'($urandom));
        end

        repeat (3) cyc();
        chk("final_queues", bitq.size() + doneq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
